// File: rtl/toom_div_arbiter.sv
// toom_div_arbiter: four requesters share one GF(2) divider (division by x^4+x^2).
// A round-robin arbiter grants one request at a time. The operand is latched,
// divided in one cycle, and the quotient is held until the consumer accepts it.
//
// state | meaning
// IDLE  | no work in flight; grants the next requester in round-robin order
// EXEC  | latched operand is being divided into q_reg
// RESP  | quotient presented on rsp_*; waits for rsp_ready
module toom_div_arbiter #(
    parameter int N    = 64,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [N-1:0]      rsp_q,
    input  logic              rsp_ready,
    output logic              busy,
    output logic [15:0]       rsp_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    logic [1:0]   rr_ptr;
    logic [1:0]   id_reg;
    logic [N-1:0] op_reg;
    logic [N-1:0] q_reg;
    logic [15:0]  count_q;

    logic         grant_found;
    logic [1:0]   grant_idx;
    logic [1:0]   scan_idx;
    logic [N-1:0] op_sel;

    // Quotient bits resolve from the top down: each bit folds in the bit two
    // places above it. The two extra zero bits at the top make the uppermost
    // quotient bits reduce to a plain copy of the operand.
    function automatic logic [N-1:0] gf2_div(input logic [N-1:0] p);
        logic [N+1:0] q;
        q = '0;
        for (int i = N - 1; i >= 2; i--) begin
            q[i] = p[i-2] ^ q[i+2];
        end
        return q[N-1:0];
    endfunction

    // Round-robin search: first valid requester at or above rr_ptr, wrapping mod 4.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        scan_idx    = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Operand slice belonging to the winning requester.
    always_comb begin
        op_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == 2'(k)) begin
                op_sel = req_data[k*N +: N];
            end
        end
    end

    // Sequencer: grant, divide, then hold the response until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= 2'd0;
            id_reg  <= 2'd0;
            op_reg  <= '0;
            q_reg   <= '0;
            count_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_reg <= op_sel;
                        id_reg <= grant_idx;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    q_reg <= gf2_div(op_reg);
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        count_q <= count_q + 16'd1;
                        rr_ptr  <= id_reg + 2'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet in any cycle where reset is asserted, even
    // before the reset edge has cleared the state register.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && grant_found) begin
            req_ready = NREQ'(1) << grant_idx;
        end
        rsp_valid = !rst && (state == RESP);
        busy      = !rst && (state != IDLE);
        rsp_id    = rst ? 2'd0 : id_reg;
        rsp_q     = rst ? '0 : q_reg;
        rsp_count = count_q;
    end

endmodule

// File: tb/tb_toom_div_arbiter.sv
// Testbench for toom_div_arbiter: a timeline model of the arbiter/divider is
// checked against the N=64 instance every cycle, with directed scenarios and a
// randomized phase; a small N=8 instance covers the narrow-width case.
module tb_toom_div_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [255:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_q;
    logic         rsp_ready = 1'b1;
    logic         busy;
    logic [15:0]  rsp_count;

    logic [3:0]   req_valid8 = '0;
    logic [31:0]  req_data8 = '0;
    logic [3:0]   req_ready8;
    logic         rsp_valid8;
    logic [1:0]   rsp_id8;
    logic [7:0]   rsp_q8;
    logic         rsp_ready8 = 1'b1;
    logic         busy8;
    logic [15:0]  rsp_count8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    toom_div_arbiter #(.N(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_ready(rsp_ready), .busy(busy), .rsp_count(rsp_count)
    );

    toom_div_arbiter #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .req_valid(req_valid8), .req_data(req_data8),
        .req_ready(req_ready8), .rsp_valid(rsp_valid8), .rsp_id(rsp_id8),
        .rsp_q(rsp_q8), .rsp_ready(rsp_ready8), .busy(busy8), .rsp_count(rsp_count8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Division by x^4+x^2 as an XOR of right shifts of p*x^2; bits 0/1 are zero.
    function automatic logic [63:0] ref_div(input logic [63:0] p);
        logic [63:0] t;
        logic [63:0] acc;
        t   = p << 2;
        acc = '0;
        for (int k = 0; k < 32; k++) acc ^= t >> (2 * k);
        return acc & ~64'h3;
    endfunction

    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // Model: either free, or holding one job with its age in cycles since grant.
    bit          m_free = 1'b1;
    int          m_age  = 0;
    int          m_ptr  = 0;
    int          m_id   = 0;
    logic [63:0] m_q    = '0;
    logic [15:0] m_cnt  = '0;

    int          c_g;
    logic [3:0]  c_rr;
    logic        c_rv;
    logic        c_busy;

    // Per-cycle compare against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        c_g = -1; c_rr = '0; c_rv = 1'b0; c_busy = 1'b0;
        if (!rst) begin
            if (m_free) begin
                c_g = pick(req_valid, m_ptr);
                if (c_g >= 0) c_rr = 4'(1 << c_g);
            end else begin
                c_busy = 1'b1;
                c_rv   = (m_age >= 2);
            end
        end
        chk("cyc_req_ready", 64'(req_ready), 64'(c_rr));
        chk("cyc_rsp_valid", 64'(rsp_valid), 64'(c_rv));
        chk("cyc_busy", 64'(busy), 64'(c_busy));
        chk("cyc_rsp_count", 64'(rsp_count), 64'(m_cnt));
        if (rst) begin
            chk("cyc_rst_rsp_id", 64'(rsp_id), 64'd0);
            chk("cyc_rst_rsp_q", rsp_q, 64'd0);
        end else if (c_rv) begin
            chk("cyc_rsp_id", 64'(rsp_id), 64'(m_id));
            chk("cyc_rsp_q", rsp_q, m_q);
        end
        if (rst) begin
            m_free = 1'b1; m_ptr = 0; m_cnt = '0;
        end else if (m_free) begin
            if (c_g >= 0) begin
                m_free = 1'b0;
                m_age  = 1;
                m_id   = c_g;
                m_q    = ref_div(req_data[c_g*64 +: 64]);
            end
        end else if (m_age >= 2) begin
            if (rsp_ready) begin
                m_cnt  = m_cnt + 16'd1;
                m_ptr  = (m_id + 1) % 4;
                m_free = 1'b1;
            end
        end else begin
            m_age++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          gid[$];
    int          gcyc[$];
    logic [15:0] cnt_snap;

    initial begin
        chk("model_div_4", ref_div(64'h4), 64'h14);
        chk("model_div_ff", ref_div(64'hFF), 64'h330);

        // Reset, then single request from requester 0 (and requester 2 on N=8)
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        req_valid = 4'b0001;
        req_data[63:0] = 64'h4;
        req_valid8 = 4'b0100;
        req_data8 = {8'h11, 8'hFF, 8'h55, 8'hAA};
        @(negedge clk);
        chk("t030_req_ready", 64'(req_ready), 64'h1);
        chk("t031_req_ready", 64'(req_ready8), 64'h4);
        tick();
        req_valid = '0;
        req_valid8 = '0;
        @(negedge clk);
        chk("t030_no_rsp_t1", 64'(rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("t030_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t030_rsp_id", 64'(rsp_id), 64'd0);
        chk("t030_rsp_q", rsp_q, 64'h14);
        chk("t031_rsp_valid", 64'(rsp_valid8), 64'd1);
        chk("t031_rsp_q", 64'(rsp_q8), 64'hCC);
        chk("t031_rsp_id", 64'(rsp_id8), 64'd2);
        tick();
        @(negedge clk);
        chk("t030_count", 64'(rsp_count), 64'd1);
        chk("t031_count", 64'(rsp_count8), 64'd1);
        chk("t031_busy", 64'(busy8), 64'd0);

        // All four requesting continuously from reset
        rst = 1'b1;
        for (int k = 0; k < 4; k++) req_data[k*64 +: 64] = {$urandom, $urandom} ^ 64'(k);
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (req_ready[k]) begin
                    gid.push_back(k);
                    gcyc.push_back(c);
                end
            end
            tick();
        end
        req_valid = '0;
        chk("t032_ngrants_ge5", 64'(gid.size() >= 5), 64'd1);
        if (gid.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("t032_order", 64'(gid[i]), 64'(i % 4));
            for (int i = 1; i < 5; i++) chk("t032_interval", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
        end
        repeat (4) tick();

        // Backpressure: requester 1 held in RESP for 10 cycles, others waiting
        req_valid = 4'b0010;
        req_data[64 +: 64] = 64'hDEAD_BEEF_0123_4567;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("t033_grant", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'b1111;
        tick();
        cnt_snap = m_cnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t033_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t033_hold_q", rsp_q, ref_div(64'hDEAD_BEEF_0123_4567));
            chk("t033_hold_id", 64'(rsp_id), 64'd1);
            chk("t033_hold_ready", 64'(req_ready), 64'd0);
            chk("t033_hold_busy", 64'(busy), 64'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("t033_count", 64'(rsp_count), 64'(cnt_snap + 16'd1));
        chk("t033_next_grant", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Reset during EXEC discards the operation
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t034_grant", 64'(req_ready), 64'h4);
        tick();
        rst = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        chk("t034_rst_busy", 64'(busy), 64'd0);
        chk("t034_rst_valid", 64'(rsp_valid), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t034_count", 64'(rsp_count), 64'd0);
        chk("t034_lowest", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            req_valid = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) req_data[k*64 +: 64] = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) tick();

        // Counter wrap from 0xFFFF
        #1;
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        m_cnt = 16'hFFFF;
        req_valid = 4'b0001;
        req_data[63:0] = 64'h0123_4567_89AB_CDEF;
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("t035_pre_count", 64'(rsp_count), 64'hFFFF);
        tick();
        @(negedge clk);
        chk("t035_wrap", 64'(rsp_count), 64'h0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
